// File: rtl/accum_ctrl.sv
// rtl/accum_ctrl.sv - handshake-driven accumulator sequencer around an external 8-bit adder.
// Optional ACCUM_SAT_EN clamps the accumulator on signed overflow instead of wrapping.
module accum_ctrl #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_op,
  input  logic             in_last,
  output logic [7:0]       add_a,
  output logic [7:0]       add_b,
  output logic             add_mode,
  input  logic [7:0]       add_sum,
  input  logic             add_carry,
  input  logic             add_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_acc,
  output logic             out_carry,
  output logic             out_ovf,
  output logic [CNT_W-1:0] out_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       acc_q, acc_d;
  logic [7:0]       opnd_q, opnd_d;
  logic             mode_q, mode_d;
  logic             last_q, last_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= 8'h00;
      opnd_q  <= 8'h00;
      mode_q  <= 1'b0;
      last_q  <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      mode_q  <= mode_d;
      last_q  <= last_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    mode_d  = mode_q;
    last_d  = last_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          opnd_d  = in_data;
          mode_d  = in_op;
          last_d  = in_last;
          state_d = EXEC;
        end
      end
      EXEC: begin
`ifdef ACCUM_SAT_EN
        // Clamp toward the sign of the pre-operation accumulator.
        if (add_ovf) begin
          acc_d = acc_q[7] ? 8'h80 : 8'h7F;
        end else begin
          acc_d = add_sum;
        end
`else
        acc_d = add_sum;
`endif
        carry_d = add_carry;
        ovf_d   = ovf_q | add_ovf;
        count_d = (count_q == {CNT_W{1'b1}}) ? count_q : count_q + CNT_W'(1);
        state_d = last_q ? DONE : IDLE;
      end
      DONE: begin
        if (out_ready) begin
          acc_d   = 8'h00;
          carry_d = 1'b0;
          ovf_d   = 1'b0;
          count_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign add_a     = acc_q;
  assign add_b     = opnd_q;
  assign add_mode  = mode_q;
  assign out_acc   = acc_q;
  assign out_carry = carry_q;
  assign out_ovf   = ovf_q;
  assign out_count = count_q;

endmodule

// File: tb/tb_accum_ctrl.sv
// tb/tb_accum_ctrl.sv - directed bench for accum_ctrl with a behavioural adder model.
// Expected results follow ACCUM_SAT_EN when the macro is defined.
module tb_accum_ctrl;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [7:0]       in_data = 8'h00;
  logic             in_op = 1'b0;
  logic             in_last = 1'b0;
  logic [7:0]       add_a;
  logic [7:0]       add_b;
  logic             add_mode;
  logic [7:0]       add_sum;
  logic             add_carry;
  logic             add_ovf;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [7:0]       out_acc;
  logic             out_carry;
  logic             out_ovf;
  logic [CNT_W-1:0] out_count;

  int n_checks = 0;
  int n_errors = 0;

  accum_ctrl #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_op     (in_op),
    .in_last   (in_last),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_mode  (add_mode),
    .add_sum   (add_sum),
    .add_carry (add_carry),
    .add_ovf   (add_ovf),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .out_carry (out_carry),
    .out_ovf   (out_ovf),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  // Subtract is a + ~b + 1; overflow when equal-signed inputs give a different-signed sum.
  logic [7:0] b_eff;
  logic [8:0] ext;
  always_comb begin
    b_eff     = add_mode ? ~add_b : add_b;
    ext       = {1'b0, add_a} + {1'b0, b_eff} + {8'h00, add_mode};
    add_sum   = ext[7:0];
    add_carry = ext[8];
    add_ovf   = (add_a[7] == b_eff[7]) && (ext[7] != add_a[7]);
  end

  task automatic send_op(input logic [7:0] d, input logic op, input logic last);
    int t;
    t = 0;
    while (!in_ready && t < 10) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) begin
      n_checks++; n_errors++;
      $display("FAIL send_op_timeout in_ready=%b required 1", in_ready);
    end
    in_valid = 1'b1; in_data = d; in_op = op; in_last = last;
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = 8'h00; in_op = 1'b0; in_last = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic finish_seq(input string name);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_acc !== 8'h00 ||
        out_count !== 4'd0 || out_ovf !== 1'b0 || out_carry !== 1'b0) begin
      n_errors++;
      $display("FAIL %s_clear got v=%b rdy=%b acc=%h cnt=%0d ovf=%b c=%b required 0 1 00 0 0 0",
               name, out_valid, in_ready, out_acc, out_count, out_ovf, out_carry);
    end
  endtask

  task automatic check_done(input string name, input logic [7:0] acc, input logic [3:0] cnt,
                            input logic c, input logic o);
    n_checks++;
    if (out_valid !== 1'b1 || out_acc !== acc || out_count !== cnt ||
        out_carry !== c || out_ovf !== o) begin
      n_errors++;
      $display("FAIL %s got v=%b acc=%h cnt=%0d c=%b ovf=%b required 1 %h %0d %b %b",
               name, out_valid, out_acc, out_count, out_carry, out_ovf, acc, cnt, c, o);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_errors++; $display("FAIL reset_in_ready_during_rst got %b required 0", in_ready);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_acc !== 8'h00 || add_b !== 8'h00 ||
        add_mode !== 1'b0 || out_count !== 4'd0 || out_carry !== 1'b0 || out_ovf !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_state got rdy=%b v=%b acc=%h b=%h m=%b cnt=%0d c=%b o=%b required 1 0 00 00 0 0 0 0",
               in_ready, out_valid, out_acc, add_b, add_mode, out_count, out_carry, out_ovf);
    end
  endtask

  task automatic test_add_seq();
    send_op(8'h05, 1'b0, 1'b0);
    n_checks++;
    if (out_acc !== 8'h05 || out_valid !== 1'b0 || in_ready !== 1'b1 || out_count !== 4'd1) begin
      n_errors++;
      $display("FAIL add_first got acc=%h v=%b rdy=%b cnt=%0d required 05 0 1 1",
               out_acc, out_valid, in_ready, out_count);
    end
    send_op(8'h03, 1'b0, 1'b1);
    check_done("add_seq", 8'h08, 4'd2, 1'b0, 1'b0);
    finish_seq("add_seq");
  endtask

  task automatic test_latency();
    in_valid = 1'b1; in_data = 8'h22; in_op = 1'b0; in_last = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
    n_checks++;
    if (in_ready !== 1'b0 || out_acc !== 8'h00 || add_b !== 8'h22) begin
      n_errors++;
      $display("FAIL exec_cycle got rdy=%b acc=%h b=%h required 0 00 22", in_ready, out_acc, add_b);
    end
    @(posedge clk); #1;
    check_done("single_op", 8'h22, 4'd1, 1'b0, 1'b0);
    finish_seq("single_op");
  endtask

  task automatic test_sub();
    send_op(8'h01, 1'b1, 1'b1);
    check_done("sub_one", 8'hFF, 4'd1, 1'b0, 1'b0);
    finish_seq("sub_one");
  endtask

  task automatic test_carry_wrap();
    send_op(8'hFF, 1'b0, 1'b0);
    send_op(8'h01, 1'b0, 1'b1);
    check_done("carry_wrap", 8'h00, 4'd2, 1'b1, 1'b0);
    finish_seq("carry_wrap");
  endtask

  task automatic test_overflow();
    send_op(8'h7F, 1'b0, 1'b0);
    send_op(8'h01, 1'b0, 1'b1);
`ifdef ACCUM_SAT_EN
    check_done("ovf_pos", 8'h7F, 4'd2, 1'b0, 1'b1);
`else
    check_done("ovf_pos", 8'h80, 4'd2, 1'b0, 1'b1);
`endif
    finish_seq("ovf_pos");
    send_op(8'h80, 1'b0, 1'b0);
    send_op(8'h01, 1'b1, 1'b0);
    n_checks++;
`ifdef ACCUM_SAT_EN
    if (out_acc !== 8'h80 || out_ovf !== 1'b1 || out_carry !== 1'b1) begin
      n_errors++;
      $display("FAIL ovf_neg got acc=%h ovf=%b c=%b required 80 1 1", out_acc, out_ovf, out_carry);
    end
`else
    if (out_acc !== 8'h7F || out_ovf !== 1'b1 || out_carry !== 1'b1) begin
      n_errors++;
      $display("FAIL ovf_neg got acc=%h ovf=%b c=%b required 7f 1 1", out_acc, out_ovf, out_carry);
    end
`endif
    send_op(8'h00, 1'b0, 1'b1);
`ifdef ACCUM_SAT_EN
    check_done("ovf_sticky", 8'h80, 4'd3, 1'b0, 1'b1);
`else
    check_done("ovf_sticky", 8'h7F, 4'd3, 1'b0, 1'b1);
`endif
    finish_seq("ovf_sticky");
  endtask

  task automatic test_hold();
    send_op(8'h11, 1'b0, 1'b1);
    in_valid = 1'b1; in_data = 8'h55;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_acc !== 8'h11 || out_count !== 4'd1 ||
          out_carry !== 1'b0 || out_ovf !== 1'b0 || add_b !== 8'h11) begin
        n_errors++;
        $display("FAIL hold_cycle%0d got v=%b rdy=%b acc=%h cnt=%0d c=%b o=%b b=%h required 1 0 11 1 0 0 11",
                 i, out_valid, in_ready, out_acc, out_count, out_carry, out_ovf, add_b);
      end
    end
    in_valid = 1'b0; in_data = 8'h00;
    finish_seq("hold");
  endtask

  task automatic test_reset_exec();
    send_op(8'h09, 1'b0, 1'b0);
    in_valid = 1'b1; in_data = 8'h04; in_op = 1'b1; in_last = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = 8'h00; in_op = 1'b0; in_last = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_errors++; $display("FAIL rst_exec_in_ready_held got %b required 0", in_ready);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_acc !== 8'h00 || add_b !== 8'h00 ||
        add_mode !== 1'b0 || out_count !== 4'd0 || out_carry !== 1'b0 || out_ovf !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_exec got rdy=%b v=%b acc=%h b=%h m=%b cnt=%0d c=%b o=%b required 1 0 00 00 0 0 0 0",
               in_ready, out_valid, out_acc, add_b, add_mode, out_count, out_carry, out_ovf);
    end
    send_op(8'h30, 1'b0, 1'b1);
    out_ready = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_acc !== 8'h00 || out_count !== 4'd0 || in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL rst_done got v=%b acc=%h cnt=%0d rdy=%b required 0 00 0 1",
               out_valid, out_acc, out_count, in_ready);
    end
  endtask

  task automatic test_count_sat();
    for (int i = 0; i < 20; i++) begin
      send_op(8'h01, 1'b0, (i == 19));
    end
    check_done("count_sat", 8'h14, 4'd15, 1'b0, 1'b0);
    finish_seq("count_sat");
  endtask

  initial begin
    test_reset();
    test_add_seq();
    test_latency();
    test_sub();
    test_carry_wrap();
    test_overflow();
    test_hold();
    test_reset_exec();
    test_count_sat();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/accum_ctrl.md
ACCUM_CTRL -- requirements
Module: accum_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 4, width of the operation counter.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset, sampled on the rising edge of clk.
REQ-004 SHALL have port in_valid, input, 1, upstream operand valid.
REQ-005 SHALL have port in_ready, output, 1, block can accept an operand.
REQ-006 SHALL have port in_data, input, 8, operand.
REQ-007 SHALL have port in_op, input, 1, 0 = add, 1 = subtract.
REQ-008 SHALL have port in_last, input, 1, final operand of the sequence.
REQ-009 SHALL have port add_a, output, 8, adder data0; always equals the accumulator.
REQ-010 SHALL have port add_b, output, 8, adder data1; the registered operand.
REQ-011 SHALL have port add_mode, output, 1, adder mode; the registered in_op.
REQ-012 SHALL have port add_sum, input, 8, adder final_sum; combinational result.
REQ-013 SHALL have ports add_carry and add_ovf, input, 1 each, adder final_carry_out and overflow.
REQ-014 SHALL have port out_valid, output, 1, result available.
REQ-015 SHALL have port out_ready, input, 1, downstream accepts the result.
REQ-016 SHALL have port out_acc, output, 8, final accumulator value.
REQ-017 SHALL have ports out_carry and out_ovf, output, 1 each, carry of the last operation and sticky overflow.
REQ-018 SHALL have port out_count, output, CNT_W, number of operations in the sequence.

Function
REQ-019 SHALL implement FSM states IDLE, EXEC and DONE.
REQ-020 SHALL drive in_ready high only in IDLE and only when rst is low.
REQ-021 In IDLE, in_valid=1 SHALL register in_data, in_op and in_last, then move to EXEC.
REQ-022 In EXEC, it SHALL load add_sum into the accumulator and add_carry into the carry flag, OR add_ovf into the sticky overflow, and increment the counter; in the same cycle it SHALL go to DONE if the registered in_last is 1, else to IDLE.
REQ-023 Throughput SHALL be one operand per 2 cycles; the accumulator SHALL update at the edge ending EXEC, one cycle after the operand is accepted.
REQ-024 In DONE, out_valid SHALL be 1 and out_acc, out_carry, out_ovf and out_count SHALL stay stable until out_valid and out_ready are both 1.
REQ-025 On that DONE handshake, the block SHALL clear the accumulator, flags and counter and return to IDLE; the next sequence starts from 0.
REQ-026 Accumulator arithmetic SHALL be 8-bit two's complement with wrap-around.
REQ-027 The counter SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-028 out_valid SHALL be 0 outside DONE; out_acc, out_carry, out_ovf and out_count SHALL reflect the live registers in every state.
REQ-029 A single operand with in_last=1 SHALL be a valid one-operation sequence.

Reset
REQ-030 rst=1 SHALL force IDLE, accumulator 0x00, operand 0x00, add_mode 0, flags 0, counter 0, and out_valid 0 at the next edge.
REQ-031 rst SHALL have priority over every handshake; a reset in EXEC or DONE SHALL discard the sequence with no output handshake.

Configuration
REQ-032 When ACCUM_SAT_EN is defined, an EXEC with add_ovf=1 SHALL load 0x7F if add_a[7]=0 and 0x80 if add_a[7]=1, instead of add_sum; out_ovf SHALL still be set.
REQ-033 When ACCUM_SAT_EN is undefined, the accumulator SHALL always load add_sum.

Verification
REQ-034 Send add 5, then add 3 with in_last=1, out_ready=1 -> out_acc=0x08, out_count=2, out_ovf=0, out_carry=0.
REQ-035 Send sub 1 with in_last=1 -> out_acc=0xFF, out_carry=0, out_ovf=0.
REQ-036 Send add 0x7F, then add 0x01 with in_last=1 -> without the macro out_acc=0x80 and out_ovf=1; with ACCUM_SAT_EN out_acc=0x7F and out_ovf=1.
REQ-037 Hold out_ready=0 for 5 cycles in DONE -> out_valid=1 with all outputs stable and in_ready=0; out_ready=1 -> IDLE with accumulator 0x00.
REQ-038 Assert rst for 1 cycle during EXEC -> next cycle is IDLE with all outputs 0 and in_ready=1.
REQ-039 Send 20 adds of 0x01 with CNT_W=4 -> out_acc=0x14 and out_count=15.
